// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, count widths and wrap limits
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/stopwatch_if.sv
// rtl/stopwatch_if.sv - button pulses in, time counts and run flag out
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic              i_run_stop;
    logic              i_clear;
    logic [MSEC_W-1:0] o_msec;
    logic [SEC_W-1:0]  o_sec;
    logic [MIN_W-1:0]  o_min;
    logic [HOUR_W-1:0] o_hour;
    logic              o_running;

    modport master (
        output i_run_stop, i_clear,
        input  o_msec, o_sec, o_min, o_hour, o_running
    );

    modport slave (
        input  i_run_stop, i_clear,
        output o_msec, o_sec, o_min, o_hour, o_running
    );

endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - gated prescaler producing one tick every CLK_HZ/TICK_HZ enabled clocks
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Holds while disabled so a resumed run keeps its partial tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign o_tick = i_en && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - run/stop/clear FSM driving a cascaded hh:mm:ss.cc counter
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        reset,
    stopwatch_if.slave  sw
);
    state_t            state_q, state_d;
    logic              running_q;
    logic              tick;
    logic              clr;
    logic [MSEC_W-1:0] msec_q;
    logic [SEC_W-1:0]  sec_q;
    logic [MIN_W-1:0]  min_q;
    logic [HOUR_W-1:0] hour_q;
    logic              msec_wrap, sec_wrap, min_wrap, hour_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STOP;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    // Clear beats run_stop when both arrive together in STOP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (sw.i_clear)         state_d = ST_CLEAR;
                else if (sw.i_run_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sw.i_run_stop) state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    assign clr = (state_q == ST_CLEAR);

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (state_q == ST_RUN),
        .i_clr  (clr),
        .o_tick (tick)
    );

    assign msec_wrap = (msec_q == MSEC_MAX);
    assign sec_wrap  = (sec_q  == SEC_MAX);
    assign min_wrap  = (min_q  == MIN_MAX);
    assign hour_wrap = (hour_q == HOUR_MAX);

    // Counters are only written on clear or tick, otherwise they hold untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else if (clr) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else if (tick) begin
            msec_q <= msec_wrap ? '0 : msec_q + 1'b1;
            if (msec_wrap) begin
                sec_q <= sec_wrap ? '0 : sec_q + 1'b1;
                if (sec_wrap) begin
                    min_q <= min_wrap ? '0 : min_q + 1'b1;
                    if (min_wrap) begin
                        hour_q <= hour_wrap ? '0 : hour_q + 1'b1;
                    end
                end
            end
        end
    end

    assign sw.o_msec    = msec_q;
    assign sw.o_sec     = sec_q;
    assign sw.o_min     = min_q;
    assign sw.o_hour    = hour_q;
    assign sw.o_running = running_q;

endmodule
